// File: rtl/stream_demux2.sv
// Registered 1-to-2 valid/ready stream demultiplexer: each beat is steered to channel a
// (in_sel_i=1) or b (in_sel_i=0) through its own one-entry slice, with delivered-beat counters.
module stream_demux2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sel_i,
    output logic              in_ready_o,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] a_data_o,
    input  logic              a_ready_i,
    output logic              b_valid_o,
    output logic [DATA_W-1:0] b_data_o,
    input  logic              b_ready_i,
    output logic [CNT_W-1:0]  a_count_o,
    output logic [CNT_W-1:0]  b_count_o
);

    logic              aValid_q, aValid_d;
    logic              bValid_q, bValid_d;
    logic [DATA_W-1:0] aData_q, aData_d;
    logic [DATA_W-1:0] bData_q, bData_d;
    logic [CNT_W-1:0]  aCount_q, aCount_d;
    logic [CNT_W-1:0]  bCount_q, bCount_d;
    logic              freeA, freeB;
    logic              acceptA, acceptB;
    logic              handshakeA, handshakeB;

    // Ready depends only on the destination slot, never on in_valid_i.
    always_comb begin
        freeA      = !aValid_q || a_ready_i;
        freeB      = !bValid_q || b_ready_i;
        in_ready_o = !reset && (in_sel_i ? freeA : freeB);
        acceptA    = in_valid_i && in_ready_o && in_sel_i;
        acceptB    = in_valid_i && in_ready_o && !in_sel_i;
        handshakeA = aValid_q && a_ready_i;
        handshakeB = bValid_q && b_ready_i;
    end

    always_comb begin
        aValid_d = aValid_q;
        aData_d  = aData_q;
        bValid_d = bValid_q;
        bData_d  = bData_q;
        aCount_d = aCount_q + {{(CNT_W-1){1'b0}}, handshakeA};
        bCount_d = bCount_q + {{(CNT_W-1){1'b0}}, handshakeB};

        if (acceptA) begin
            aValid_d = 1'b1;
            aData_d  = in_data_i;
        end else if (a_ready_i) begin
            aValid_d = 1'b0;
        end

        if (acceptB) begin
            bValid_d = 1'b1;
            bData_d  = in_data_i;
        end else if (b_ready_i) begin
            bValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aValid_q <= 1'b0;
            bValid_q <= 1'b0;
            aData_q  <= '0;
            bData_q  <= '0;
            aCount_q <= '0;
            bCount_q <= '0;
        end else begin
            aValid_q <= aValid_d;
            bValid_q <= bValid_d;
            aData_q  <= aData_d;
            bData_q  <= bData_d;
            aCount_q <= aCount_d;
            bCount_q <= bCount_d;
        end
    end

    assign a_valid_o = aValid_q;
    assign a_data_o  = aData_q;
    assign b_valid_o = bValid_q;
    assign b_data_o  = bData_q;
    assign a_count_o = aCount_q;
    assign b_count_o = bCount_q;

endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2: per-channel scoreboards are filled on accepted beats
// and drained on output handshakes, with counts and valids tracked alongside.
module tb_stream_demux2;

    logic       clk;
    logic       reset;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_sel_i;
    logic       in_ready_o;
    logic       a_valid_o;
    logic [7:0] a_data_o;
    logic       a_ready_i;
    logic       b_valid_o;
    logic [7:0] b_data_o;
    logic       b_ready_i;
    logic [7:0] a_count_o;
    logic [7:0] b_count_o;

    logic [7:0] queueA[$];
    logic [7:0] queueB[$];
    logic [7:0] modelCountA;
    logic [7:0] modelCountB;
    bit         modelKnown;
    int         acceptedBeats;
    int         totalChecks;
    int         passedChecks;

    stream_demux2 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_sel_i   (in_sel_i),
        .in_ready_o (in_ready_o),
        .a_valid_o  (a_valid_o),
        .a_data_o   (a_data_o),
        .a_ready_i  (a_ready_i),
        .b_valid_o  (b_valid_o),
        .b_data_o   (b_data_o),
        .b_ready_i  (b_ready_i),
        .a_count_o  (a_count_o),
        .b_count_o  (b_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic sel, input logic [7:0] data,
                                 input logic aReady, input logic bReady);
        in_valid_i = valid;
        in_sel_i   = sel;
        in_data_i  = data;
        a_ready_i  = aReady;
        b_ready_i  = bReady;
    endtask

    // One clock: sample at the falling edge, then update the model at the rising edge.
    task automatic step();
        logic expReady, accA, accB, hsA, hsB, expValidA, expValidB;
        @(negedge clk);
        expValidA = (queueA.size() != 0);
        expValidB = (queueB.size() != 0);
        if (reset)
            expReady = 1'b0;
        else
            expReady = in_sel_i ? (!expValidA || a_ready_i) : (!expValidB || b_ready_i);
        checkOutput("in_ready", in_ready_o, expReady);
        if (modelKnown) begin
            checkOutput("a_valid", a_valid_o, expValidA);
            checkOutput("b_valid", b_valid_o, expValidB);
            if (expValidA) checkOutput("a_data", a_data_o, queueA[0]);
            if (expValidB) checkOutput("b_data", b_data_o, queueB[0]);
            checkOutput("a_count", a_count_o, modelCountA);
            checkOutput("b_count", b_count_o, modelCountB);
        end
        accA = in_valid_i && expReady && in_sel_i;
        accB = in_valid_i && expReady && !in_sel_i;
        hsA  = expValidA && a_ready_i;
        hsB  = expValidB && b_ready_i;
        @(posedge clk);
        if (reset) begin
            queueA.delete();
            queueB.delete();
            modelCountA = 8'd0;
            modelCountB = 8'd0;
            modelKnown  = 1'b1;
        end else begin
            if (hsA) begin
                void'(queueA.pop_front());
                modelCountA = modelCountA + 8'd1;
            end
            if (hsB) begin
                void'(queueB.pop_front());
                modelCountB = modelCountB + 8'd1;
            end
            if (accA) queueA.push_back(in_data_i);
            if (accB) queueB.push_back(in_data_i);
            if (accA || accB) acceptedBeats++;
        end
        #1;
    endtask

    initial begin
        totalChecks   = 0;
        passedChecks  = 0;
        acceptedBeats = 0;
        modelKnown    = 1'b0;
        modelCountA   = 8'd0;
        modelCountB   = 8'd0;

        // Reset held two cycles while a beat is offered.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        step();
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("reset_a_data", a_data_o, 8'h00);
        checkOutput("reset_b_data", b_data_o, 8'h00);
        checkOutput("reset_a_count", a_count_o, 8'd0);

        // Steering.
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        step();
        checkOutput("steer_a_data", a_data_o, 8'h3C);
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        step();
        checkOutput("steer_b_data", b_data_o, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        step();
        checkOutput("steer_a_count", a_count_o, 8'd1);
        checkOutput("steer_b_count", b_count_o, 8'd1);

        // Backpressure on channel a.
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_a_data", a_data_o, 8'h11);
            checkOutput("stall_in_ready", in_ready_o, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        step();
        checkOutput("refill_a_data", a_data_o, 8'h22);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();

        // Channel b proceeds while channel a is stalled.
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
        step();
        checkOutput("indep_b_valid", b_valid_o, 1'b1);
        checkOutput("indep_b_data", b_data_o, 8'h55);
        checkOutput("indep_a_data", a_data_o, 8'h33);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        step();

        // Full rate from a clean start.
        reset = 1'b1;
        step();
        reset = 1'b0;
        acceptedBeats = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, 8'(i * 7 + 3), 1'b1, 1'b1);
            step();
        end
        checkOutput("fullrate_accepts", acceptedBeats, 300);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("fullrate_a_count", a_count_o, 8'd150);
        checkOutput("fullrate_b_count", b_count_o, 8'd150);

        // Reset while both channels are full and stalled.
        applyStimulus(1'b1, 1'b1, 8'h61, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 8'h62, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("midreset_a_valid", a_valid_o, 1'b0);
        checkOutput("midreset_b_valid", b_valid_o, 1'b0);
        checkOutput("midreset_a_data", a_data_o, 8'h00);
        checkOutput("midreset_b_count", b_count_o, 8'd0);
        step();
        step();

        checkOutput("scoreboard_a_empty", queueA.size(), 0);
        checkOutput("scoreboard_b_empty", queueB.size(), 0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
